// File: rtl/ahb_wb_pkg.sv
// Shared AHB/Wishbone bridge types, size codes and byte-lane helper.
package ahb_wb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Contiguous run of 2^hsize ones starting at the lane offset, clipped to nbytes lanes.
    function automatic logic [7:0] sel_from_size(input logic [2:0] hsize,
                                                 input logic [2:0] addr_lsbs,
                                                 input int unsigned nbytes);
        logic [15:0] run;
        logic [15:0] lanes;
        run   = (16'd1 << (4'd1 << hsize)) - 16'd1;
        lanes = (run << addr_lsbs) & ((16'd1 << nbytes) - 16'd1);
        return lanes[7:0];
    endfunction

endpackage

// File: rtl/ahb_wb_lane_decode.sv
// Combinational legality check and Wishbone byte-select generation for 32/64-bit buses.
module ahb_wb_lane_decode
    import ahb_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]                        hsize,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   addr_lsbs,
    output logic                              legal_c,
    output logic [DATA_WIDTH/8-1:0]           sel_c
);

    localparam int unsigned NBYTES   = DATA_WIDTH / 8;
    localparam logic [2:0]  MAX_SIZE = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

    logic [7:0] align_mask;

    always_comb begin
        align_mask = 8'((9'd1 << hsize) - 9'd1);
        legal_c    = (hsize <= MAX_SIZE) && ((8'(addr_lsbs) & align_mask) == 8'd0);
        sel_c      = '0;
        if (legal_c) begin
            sel_c = NBYTES'(sel_from_size(hsize, 3'(addr_lsbs), NBYTES));
        end
    end

endmodule

// File: rtl/ahb_wb_bridge_v2.sv
// AHB-Lite slave to Wishbone classic master bridge, one transfer per Wishbone cycle.
// Optional data-phase timeout enabled by defining AHB_WB_TIMEOUT_EN.
module ahb_wb_bridge_v2
    import ahb_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [DATA_WIDTH-1:0]     hwdata,
    input  logic                      hready,
    output logic                      hready_out,
    output logic                      hresp,
    output logic [DATA_WIDTH-1:0]     hrdata,
    output logic                      wb_cyc,
    output logic                      wb_stb,
    output logic                      wb_we,
    output logic [ADDR_WIDTH-1:0]     wb_adr,
    output logic [DATA_WIDTH/8-1:0]   wb_sel,
    output logic [DATA_WIDTH-1:0]     wb_dat_w,
    input  logic [DATA_WIDTH-1:0]     wb_dat_r,
    input  logic                      wb_ack,
    input  logic                      wb_err
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NBYTES - 1);

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535)
    begin : g_bad_param
        $error("ahb_wb_bridge_v2: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    state_t                  state_q, state_d;
    logic                    wb_cyc_q, wb_cyc_d;
    logic                    wb_we_q, wb_we_d;
    logic [ADDR_WIDTH-1:0]   wb_adr_q, wb_adr_d;
    logic [NBYTES-1:0]       wb_sel_q, wb_sel_d;

    htrans_t                 trans_c;
    logic                    accept_c;
    logic                    open_c;
    logic                    done_c;
    logic                    legal_c;
    logic [NBYTES-1:0]       sel_c;
    logic                    tmo_hit_c;

    ahb_wb_lane_decode #(.DATA_WIDTH(DATA_WIDTH)) u_lane_decode (
        .hsize     (hsize),
        .addr_lsbs (haddr[OFF_W-1:0]),
        .legal_c   (legal_c),
        .sel_c     (sel_c)
    );

    assign trans_c  = htrans_t'(htrans);
    assign accept_c = hready && (trans_c == HTRANS_NONSEQ || trans_c == HTRANS_SEQ);
    assign done_c   = wb_ack && !wb_err;

    assign wb_cyc   = wb_cyc_q;
    assign wb_stb   = wb_cyc_q;
    assign wb_we    = wb_we_q;
    assign wb_adr   = wb_adr_q;
    assign wb_sel   = wb_sel_q;
    assign wb_dat_w = hwdata;

    // open_c marks cycles in which a new address phase may be taken.
    always_comb begin
        state_d    = state_q;
        wb_cyc_d   = wb_cyc_q;
        wb_we_d    = wb_we_q;
        wb_adr_d   = wb_adr_q;
        wb_sel_d   = wb_sel_q;
        hready_out = 1'b1;
        hresp      = 1'b0;
        hrdata     = '0;
        open_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: open_c = 1'b1;
            ST_DATA: begin
                hready_out = done_c;
                if (done_c) begin
                    hrdata = wb_dat_r;
                end
                if (wb_err) begin
                    state_d  = ST_ERR1;
                    wb_cyc_d = 1'b0;
                end else if (wb_ack) begin
                    state_d  = ST_IDLE;
                    wb_cyc_d = 1'b0;
                    open_c   = 1'b1;
                end else if (tmo_hit_c) begin
                    state_d  = ST_ERR1;
                    wb_cyc_d = 1'b0;
                end
            end
            ST_ERR1: begin
                hresp      = 1'b1;
                hready_out = 1'b0;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = 1'b1;
                open_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (open_c && accept_c) begin
            if (legal_c) begin
                state_d  = ST_DATA;
                wb_cyc_d = 1'b1;
                wb_we_d  = hwrite;
                wb_adr_d = haddr & ~LANE_MASK;
                wb_sel_d = sel_c;
            end else begin
                state_d  = ST_ERR1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wb_cyc_q <= 1'b0;
            wb_we_q  <= 1'b0;
            wb_adr_q <= '0;
            wb_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            wb_cyc_q <= wb_cyc_d;
            wb_we_q  <= wb_we_d;
            wb_adr_q <= wb_adr_d;
            wb_sel_q <= wb_sel_d;
        end
    end

`ifdef AHB_WB_TIMEOUT_EN
    localparam int unsigned TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TMO_W   = (TMO_RAW < 8) ? 8 : ((TMO_RAW > 16) ? 16 : TMO_RAW);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts DATA cycles without a slave response; restarts on every new transfer.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d == ST_DATA && (state_q != ST_DATA || done_c)) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_DATA && !wb_ack && !wb_err) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_hit_c = (state_q == ST_DATA) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_wb_bridge_v2.sv
// Self-checking bench for ahb_wb_bridge_v2 (32-bit instance plus a 64-bit lane check).
module tb_ahb_wb_bridge_v2;
    import ahb_wb_pkg::*;

`ifdef AHB_WB_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_out;
    logic        hresp;
    logic [31:0] hrdata;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_err;

    logic [31:0] h6_addr;
    logic [1:0]  h6_trans;
    logic        h6_write;
    logic [2:0]  h6_size;
    logic [63:0] h6_wdata;
    logic        h6_ready, h6_ready_out, h6_resp;
    logic [63:0] h6_rdata;
    logic        w6_cyc, w6_stb, w6_we;
    logic [31:0] w6_adr;
    logic [7:0]  w6_sel;
    logic [63:0] w6_dat_w;
    logic [63:0] w6_dat_r;
    logic        w6_ack, w6_err;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        legal;
        logic [31:0] adr;
        logic [3:0]  sel;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  cur_exp;
    logic in_dphase = 1'b0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    assign hready   = hready_out;
    assign h6_ready = h6_ready_out;

    ahb_wb_bridge_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hready(hready), .hready_out(hready_out),
        .hresp(hresp), .hrdata(hrdata), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    ahb_wb_bridge_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TMO)) dut64 (
        .clk(clk), .rst(rst), .haddr(h6_addr), .htrans(h6_trans), .hwrite(h6_write),
        .hsize(h6_size), .hwdata(h6_wdata), .hready(h6_ready), .hready_out(h6_ready_out),
        .hresp(h6_resp), .hrdata(h6_rdata), .wb_cyc(w6_cyc), .wb_stb(w6_stb), .wb_we(w6_we),
        .wb_adr(w6_adr), .wb_sel(w6_sel), .wb_dat_w(w6_dat_w), .wb_dat_r(w6_dat_r),
        .wb_ack(w6_ack), .wb_err(w6_err)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // AHB-side monitor: completes data phases against the scoreboard, then records new address phases.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            in_dphase = 1'b0;
        end else begin
            if (in_dphase && hready_out) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: completion with no pending transfer (t=%0t)", $time);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("hresp", 64'(hresp), 64'(e.err));
                    if (!e.err && !e.wr) check("hrdata", 64'(hrdata), 64'(e.rdata));
                end
            end
            if (hready) in_dphase = htrans[1];
            if (hready && htrans[1]) sb_q.push_back(cur_exp);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [2:0] s, input logic w,
                              input logic err, input logic [31:0] rd);
        cur_exp = '{err: err, wr: w, rdata: rd};
        htrans  = HTRANS_NONSEQ;
        haddr   = a;
        hsize   = s;
        hwrite  = w;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        addr_phase(v.addr, v.size, v.wr, !v.legal, v.rdata);
        @(negedge clk);
        next_cycle();
        htrans = HTRANS_IDLE;
        hwdata = v.wdata;
        if (v.legal) begin
            for (int w = 0; w <= v.waits; w++) begin
                wb_ack   = (w == v.waits);
                wb_dat_r = v.rdata;
                @(negedge clk);
                if (w == 0) begin
                    check($sformatf("v%0d wb_cyc", idx), 64'(wb_cyc), 64'd1);
                    check($sformatf("v%0d wb_stb", idx), 64'(wb_stb), 64'd1);
                    check($sformatf("v%0d wb_adr", idx), 64'(wb_adr), 64'(v.adr));
                    check($sformatf("v%0d wb_sel", idx), 64'(wb_sel), 64'(v.sel));
                    check($sformatf("v%0d wb_we", idx), 64'(wb_we), 64'(v.wr));
                    if (v.wr) check($sformatf("v%0d wb_dat_w", idx), 64'(wb_dat_w), 64'(v.wdata));
                end
                check($sformatf("v%0d hready_out", idx), 64'(hready_out), 64'(w == v.waits));
                next_cycle();
            end
            wb_ack = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d cyc_drop", idx), 64'(wb_cyc), 64'd0);
            next_cycle();
        end else begin
            @(negedge clk);
            check($sformatf("v%0d err1_cyc", idx), 64'(wb_cyc), 64'd0);
            check($sformatf("v%0d err1_hresp", idx), 64'(hresp), 64'd1);
            check($sformatf("v%0d err1_hready", idx), 64'(hready_out), 64'd0);
            next_cycle();
            @(negedge clk);
            check($sformatf("v%0d err2_hready", idx), 64'(hready_out), 64'd1);
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr:32'h100, size:HSIZE_WORD,  wr:1'b0, wdata:32'h0,         waits:0,
                    rdata:32'hCAFEF00D, legal:1'b1, adr:32'h100, sel:4'hF};
        vecs[1] = '{addr:32'h203, size:HSIZE_BYTE,  wr:1'b1, wdata:32'hAA000000, waits:0,
                    rdata:32'h0,        legal:1'b1, adr:32'h200, sel:4'h8};
        vecs[2] = '{addr:32'h102, size:HSIZE_HALF,  wr:1'b1, wdata:32'hBEEF0000, waits:1,
                    rdata:32'h0,        legal:1'b1, adr:32'h100, sel:4'hC};
        vecs[3] = '{addr:32'h101, size:HSIZE_BYTE,  wr:1'b0, wdata:32'h0,         waits:2,
                    rdata:32'h00005500, legal:1'b1, adr:32'h100, sel:4'h2};
        vecs[4] = '{addr:32'h102, size:HSIZE_WORD,  wr:1'b0, wdata:32'h0,         waits:0,
                    rdata:32'h0,        legal:1'b0, adr:32'h0,   sel:4'h0};
        vecs[5] = '{addr:32'h100, size:HSIZE_DWORD, wr:1'b0, wdata:32'h0,         waits:0,
                    rdata:32'h0,        legal:1'b0, adr:32'h0,   sel:4'h0};
        vecs[6] = '{addr:32'h101, size:HSIZE_HALF,  wr:1'b1, wdata:32'h0,         waits:0,
                    rdata:32'h0,        legal:1'b0, adr:32'h0,   sel:4'h0};
        vecs[7] = '{addr:32'h3FC, size:HSIZE_WORD,  wr:1'b1, wdata:32'h01234567, waits:0,
                    rdata:32'h0,        legal:1'b1, adr:32'h3FC, sel:4'hF};

        cur_exp  = '{err: 1'b0, wr: 1'b0, rdata: 32'h0};
        rst      = 1'b1;
        haddr    = 32'h100;
        htrans   = HTRANS_NONSEQ;
        hwrite   = 1'b0;
        hsize    = HSIZE_WORD;
        hwdata   = '0;
        wb_dat_r = '0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        h6_addr  = '0;
        h6_trans = HTRANS_IDLE;
        h6_write = 1'b0;
        h6_size  = HSIZE_BYTE;
        h6_wdata = '0;
        w6_dat_r = '0;
        w6_ack   = 1'b0;
        w6_err   = 1'b0;

        // Reset held with a pending NONSEQ request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst wb_cyc", 64'(wb_cyc), 64'd0);
            check("rst hready_out", 64'(hready_out), 64'd1);
            check("rst hresp", 64'(hresp), 64'd0);
            next_cycle();
        end
        rst    = 1'b0;
        htrans = HTRANS_IDLE;
        next_cycle();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Back-to-back reads with no bubble.
        addr_phase(32'h100, HSIZE_WORD, 1'b0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        next_cycle();
        addr_phase(32'h104, HSIZE_WORD, 1'b0, 1'b0, 32'h12345678);
        wb_ack   = 1'b1;
        wb_dat_r = 32'hDEADBEEF;
        @(negedge clk);
        check("b2b cyc0", 64'(wb_cyc), 64'd1);
        check("b2b adr0", 64'(wb_adr), 64'h100);
        next_cycle();
        htrans   = HTRANS_IDLE;
        wb_dat_r = 32'h12345678;
        @(negedge clk);
        check("b2b cyc1", 64'(wb_cyc), 64'd1);
        check("b2b adr1", 64'(wb_adr), 64'h104);
        next_cycle();
        wb_ack = 1'b0;
        @(negedge clk);
        check("b2b cyc_drop", 64'(wb_cyc), 64'd0);
        next_cycle();

        // Wishbone error on the third data-phase cycle, then a NONSEQ taken in ERR2.
        addr_phase(32'h180, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        next_cycle();
        htrans = HTRANS_IDLE;
        for (int w = 0; w < 3; w++) begin
            wb_err = (w == 2);
            @(negedge clk);
            check("err wait_hready", 64'(hready_out), 64'd0);
            check("err wait_hresp", 64'(hresp), 64'd0);
            next_cycle();
        end
        wb_err = 1'b0;
        @(negedge clk);
        check("err1 cyc", 64'(wb_cyc), 64'd0);
        check("err1 hresp", 64'(hresp), 64'd1);
        check("err1 hready", 64'(hready_out), 64'd0);
        next_cycle();
        addr_phase(32'h104, HSIZE_WORD, 1'b0, 1'b0, 32'h0BADF00D);
        @(negedge clk);
        check("err2 hresp", 64'(hresp), 64'd1);
        check("err2 hready", 64'(hready_out), 64'd1);
        next_cycle();
        htrans   = HTRANS_IDLE;
        wb_ack   = 1'b1;
        wb_dat_r = 32'h0BADF00D;
        @(negedge clk);
        check("post_err cyc", 64'(wb_cyc), 64'd1);
        check("post_err adr", 64'(wb_adr), 64'h104);
        next_cycle();
        wb_ack = 1'b0;
        next_cycle();

`ifdef AHB_WB_TIMEOUT_EN
        // No ack: error after TMO data cycles; a late ack during ERR1 is ignored.
        addr_phase(32'h100, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        next_cycle();
        htrans = HTRANS_IDLE;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            check("tmo wait_cyc", 64'(wb_cyc), 64'd1);
            check("tmo wait_hready", 64'(hready_out), 64'd0);
            next_cycle();
        end
        wb_ack = 1'b1;
        @(negedge clk);
        check("tmo err1_cyc", 64'(wb_cyc), 64'd0);
        check("tmo err1_hresp", 64'(hresp), 64'd1);
        check("tmo err1_hready", 64'(hready_out), 64'd0);
        next_cycle();
        wb_ack = 1'b0;
        @(negedge clk);
        check("tmo err2_hresp", 64'(hresp), 64'd1);
        next_cycle();
        @(negedge clk);
        check("tmo idle_cyc", 64'(wb_cyc), 64'd0);
        next_cycle();
`endif

        // Reset in the middle of a data phase.
        addr_phase(32'h40, HSIZE_WORD, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        next_cycle();
        htrans = HTRANS_IDLE;
        @(negedge clk);
        check("rst_mid cyc_before", 64'(wb_cyc), 64'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid cyc_after", 64'(wb_cyc), 64'd0);
        check("rst_mid hready", 64'(hready_out), 64'd1);
        next_cycle();

        // 64-bit lanes: halfword write at 0x206, then misaligned dword.
        h6_trans = HTRANS_NONSEQ;
        h6_addr  = 32'h206;
        h6_size  = HSIZE_HALF;
        h6_write = 1'b1;
        next_cycle();
        h6_trans = HTRANS_IDLE;
        w6_ack   = 1'b1;
        @(negedge clk);
        check("w64 cyc", 64'(w6_cyc), 64'd1);
        check("w64 sel", 64'(w6_sel), 64'hC0);
        check("w64 adr", 64'(w6_adr), 64'h200);
        next_cycle();
        w6_ack   = 1'b0;
        h6_trans = HTRANS_NONSEQ;
        h6_addr  = 32'h204;
        h6_size  = HSIZE_DWORD;
        h6_write = 1'b0;
        next_cycle();
        h6_trans = HTRANS_IDLE;
        @(negedge clk);
        check("w64 err_cyc", 64'(w6_cyc), 64'd0);
        check("w64 err_hresp", 64'(h6_resp), 64'd1);
        next_cycle();
        next_cycle();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_wb_bridge_v2.md
Name: ahb_wb_bridge_v2

Overview:
Parametrised AHB-Lite slave to Wishbone classic master bridge sitting between a core's AHB port and the processorci bus (core_cyc/core_stb/...). It converts one AHB transfer at a time into one Wishbone cycle and supports DATA_WIDTH 32 or 64. It derives byte selects from HSIZE and HADDR, supports zero-bubble back-to-back transfers, and gives a proper two-cycle AHB ERROR response on misaligned or oversize access, on Wishbone err, and optionally on timeout.

Parameters:
ADDR_WIDTH, 32, address width on both sides
DATA_WIDTH, 32, data width; legal values 32 or 64
TIMEOUT_CYCLES, 255, data-phase cycles before timeout error; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
haddr  in  ADDR_WIDTH  AHB address
htrans  in  2  AHB transfer type
hwrite  in  1  AHB write
hsize  in  3  AHB transfer size
hwdata  in  DATA_WIDTH  AHB write data, valid in data phase
hready  in  1  bus HREADY, qualifies address phase
hready_out  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  DATA_WIDTH  read data
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  Wishbone write enable
wb_adr  out  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits zero)
wb_sel  out  DATA_WIDTH/8  byte selects
wb_dat_w  out  DATA_WIDTH  write data
wb_dat_r  in  DATA_WIDTH  read data
wb_ack  in  1  Wishbone acknowledge
wb_err  in  1  Wishbone error

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Reset values: state IDLE, wb_cyc/wb_stb/wb_we = 0, wb_adr = 0, wb_sel = 0, hresp = 0, hready_out = 1.
- Address phase is accepted when hready & htrans[1] (NONSEQ or SEQ) in IDLE, or in the completing cycle of DATA or ERR2. IDLE and BUSY transfers complete zero-wait OKAY and start nothing.
- Legality check: hsize ≤ log2(DATA_WIDTH/8) and haddr aligned to 2^hsize. An illegal transfer goes to ERR1 without starting a Wishbone cycle.
- Legal transfer: registers wb_adr, wb_we, wb_sel and the size/lane info. wb_sel is a contiguous run of 2^hsize ones starting at haddr's lane offset. State moves to DATA.
- DATA:
  - wb_cyc = wb_stb = 1 from the cycle after address acceptance.
  - wb_dat_w is driven combinationally from hwdata; AHB holds hwdata stable during the data phase.
  - hready_out = wb_ack.
  - hrdata = wb_dat_r, passed through combinationally and qualified by ack; 0 otherwise.
- DATA exits:
  - wb_ack with no new address phase: wb_cyc/wb_stb drop next edge, state IDLE.
  - wb_ack with a new legal address phase in the same cycle: stay in DATA, strobes stay high, new address loaded. Zero bubble.
- wb_err (takes priority over a simultaneous wb_ack): drop wb_cyc/wb_stb next edge, go to ERR1.
- ERR1: hresp = 1, hready_out = 0. Any address phase presented here is ignored.
- ERR2: hresp = 1, hready_out = 1. Address phase sampled normally (master may cancel with IDLE).
- Read latency with single-cycle ack: transfer completes in cycle A+1.
- rst mid-transfer: strobes deassert at the next edge and no response is completed.

Optional Feature:
- Macro: AHB_WB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering DATA and increments each DATA cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES, the bridge drops wb_cyc/wb_stb and goes to ERR1.
  - A late wb_ack after the timeout is ignored.
- Undefined: no counter; DATA waits indefinitely.

Decomposition:
- Package ahb_wb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - hsize constants (BYTE, HALF, WORD, DWORD)
  - bridge state enum (IDLE, DATA, ERR1, ERR2)
  - function sel_from_size(hsize, addr_lsbs, nbytes)
- Sub-module ahb_wb_lane_decode: combinational legality check plus wb_sel generation, reused by the 32- and 64-bit variants.

Test Plan:
- Reset behaviour: hold rst 3 cycles with htrans = NONSEQ -> wb_cyc = 0, hready_out = 1, hresp = 0 throughout.
- Back-to-back reads: DATA_WIDTH = 32, NONSEQ reads at 0x100 then 0x104, slave acks every cycle returning 0xDEADBEEF / 0x12345678 -> wb_cyc continuous for 2 cycles, hrdata matches, no bubble.
- Byte-lane writes:
  - Byte write at 0x203, hwdata = 0xAA000000 -> wb_sel = 4'b1000, wb_adr = 0x200, wb_we = 1.
  - On DATA_WIDTH = 64, halfword write at 0x206 -> wb_sel = 8'b1100_0000.
- Illegal access:
  - Word read at 0x102 -> no wb_cyc; two cycles hresp = 1 with hready_out 0 then 1.
  - hsize = DWORD on 32-bit -> same response.
- Wishbone error: wb_err on the 3rd wait cycle -> strobes drop next edge, ERR1/ERR2 response, following NONSEQ in ERR2 accepted.
- Timeout (AHB_WB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): no ack -> error response starting after 4 DATA cycles; a wb_ack injected one cycle later is ignored.
